// File: rtl/pipeline_trace_monitor_if.sv
// Trace monitor bus: CPU observation samples, run control, trace read port
// and status. master drives the samples and controls; slave is the monitor.
interface pipeline_trace_monitor_if #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = 16,
   parameter int JUMP_W = 3
);
   localparam int TC_W = $clog2(DEPTH) + 1;

   logic              enable;
   logic              clear;
   logic [DATA_W-1:0] pc;
   logic [DATA_W-1:0] instr;
   logic              stall;
   logic [JUMP_W-1:0] jump_flag;
   logic              rd_req;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_pc;
   logic [DATA_W-1:0] rd_instr;
   logic [TC_W-1:0]   trace_count;
   logic [CNT_W-1:0]  cycle_cnt;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  jump_cnt;
   logic              overflow;
   logic              done;
   logic              busy;

   modport master (
      output enable, clear, pc, instr, stall, jump_flag, rd_req,
      input  rd_valid, rd_pc, rd_instr, trace_count, cycle_cnt,
             stall_cnt, jump_cnt, overflow, done, busy
   );

   modport slave (
      input  enable, clear, pc, instr, stall, jump_flag, rd_req,
      output rd_valid, rd_pc, rd_instr, trace_count, cycle_cnt,
             stall_cnt, jump_cnt, overflow, done, busy
   );
endinterface

// File: rtl/pipeline_trace_monitor.sv
// Pipeline trace monitor: counts cycles, stalls and taken redirects while
// running, and buffers non-stalled {pc, instr} pairs in a trace FIFO.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for enable, nothing sampled
// ST_RUN  | sampling on every edge with enable=1 (enable=0 pauses)
// ST_DONE | cycle budget used up, counters/FIFO frozen until clear
module pipeline_trace_monitor #(
   parameter int DATA_W     = 32,
   parameter int DEPTH      = 16,
   parameter int CNT_W      = 16,
   parameter int MAX_CYCLES = 25,
   parameter int JUMP_W     = 3
) (
   input logic clk,
   input logic reset,
   pipeline_trace_monitor_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int TC_W  = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_SAT  = '1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);
   localparam logic [TC_W-1:0]  TC_FULL  = TC_W'(DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   state_t state, state_nxt;

   logic [2*DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic [TC_W-1:0]     count;
   logic [CNT_W-1:0]    cycle_cnt, stall_cnt, jump_cnt;
   logic                overflow, rd_valid;
   logic [DATA_W-1:0]   rd_pc, rd_instr;
   logic                sample, push, pop, accept, full, empty;

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // next state; the edge that reaches the budget is still sampled
   always_comb begin
      state_nxt = state;
      sample    = 1'b0;
      case (state)
         ST_IDLE: if (bus.enable) state_nxt = ST_RUN;
         ST_RUN: begin
            if (bus.enable) begin
               sample = 1'b1;
               if (cycle_cnt == CNT_LAST) state_nxt = ST_DONE;
            end
         end
         ST_DONE: state_nxt = ST_DONE;
         default: state_nxt = ST_IDLE;
      endcase
      if (bus.clear) begin
         state_nxt = ST_IDLE;
         sample    = 1'b0;
      end
   end

   assign full   = (count == TC_FULL);
   assign empty  = (count == '0);
   assign pop    = bus.rd_req && !empty && !bus.clear;
   assign push   = sample && !bus.stall;
   // a pop in the same cycle frees the slot, so a full FIFO still accepts
   assign accept = push && (!full || pop);

   // FIFO pointers, occupancy and sticky overflow
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (bus.clear) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + 1'b1;
         if (pop)    rd_ptr <= rd_ptr + 1'b1;
         if (accept && !pop)      count <= count + 1'b1;
         else if (pop && !accept) count <= count - 1'b1;
         if (push && !accept) overflow <= 1'b1;
      end
   end

   // trace storage; stale contents are unreachable once pointers reset
   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= {bus.pc, bus.instr};
   end

   // read port: one-cycle pulse, data held between pops
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_valid <= 1'b0;
         rd_pc    <= '0;
         rd_instr <= '0;
      end else begin
         rd_valid <= pop;
         if (pop) {rd_pc, rd_instr} <= mem[rd_ptr];
      end
   end

   // run counters; stall/jump saturate, cycle count is capped by DONE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cycle_cnt <= '0;
         stall_cnt <= '0;
         jump_cnt  <= '0;
      end else if (bus.clear) begin
         cycle_cnt <= '0;
         stall_cnt <= '0;
         jump_cnt  <= '0;
      end else if (sample) begin
         cycle_cnt <= cycle_cnt + 1'b1;
         if (bus.stall && stall_cnt != CNT_SAT) stall_cnt <= stall_cnt + 1'b1;
         if ((bus.jump_flag != '0) && jump_cnt != CNT_SAT) jump_cnt <= jump_cnt + 1'b1;
      end
   end

   assign bus.rd_valid    = rd_valid;
   assign bus.rd_pc       = rd_pc;
   assign bus.rd_instr    = rd_instr;
   assign bus.trace_count = count;
   assign bus.cycle_cnt   = cycle_cnt;
   assign bus.stall_cnt   = stall_cnt;
   assign bus.jump_cnt    = jump_cnt;
   assign bus.overflow    = overflow;
   assign bus.done        = (state == ST_DONE);
   assign bus.busy        = (state == ST_RUN);
endmodule

// File: doc/pipeline_trace_monitor.md
Name: pipeline_trace_monitor

Overview:
Synthesizable observation block that sits beside the pipelined CPU core. It samples PC, ID-stage instruction, Stall and JumpFlag every cycle. It keeps cycle, stall and jump counters and buffers non-stalled {PC, instruction} pairs in a trace FIFO that can be read out later. It terminates the run after a programmable cycle budget.

Parameters:
DATA_W, 32, width of PC and instruction samples
DEPTH, 16, trace FIFO entries; power of 2, minimum 2
CNT_W, 16, width of cycle/stall/jump counters
MAX_CYCLES, 25, RUN-state cycles before DONE; range 1..2^CNT_W-1
JUMP_W, 3, width of jump flag input

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
enable  in  1  start/continue monitoring
clear  in  1  synchronous clear back to IDLE
pc  in  DATA_W  CPU PC sample
instr  in  DATA_W  ID-stage instruction sample
stall  in  1  CPU stall indicator
jump_flag  in  JUMP_W  CPU jump/branch flags; nonzero means a taken redirect
rd_req  in  1  pop one trace entry
rd_valid  out  1  rd_pc/rd_instr valid this cycle
rd_pc  out  DATA_W  popped PC
rd_instr  out  DATA_W  popped instruction
trace_count  out  log2(DEPTH)+1  FIFO occupancy
cycle_cnt  out  CNT_W  cycles counted in RUN
stall_cnt  out  CNT_W  stalled cycles counted
jump_cnt  out  CNT_W  nonzero jump_flag cycles counted
overflow  out  1  sticky; a push was dropped because the FIFO was full
done  out  1  run budget reached
busy  out  1  state is RUN

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. All counters 0, FIFO empty, trace_count=0. rd_valid=0, rd_pc=0, rd_instr=0, overflow=0, done=0, busy=0.
- States:
  - IDLE -> RUN when enable=1.
  - RUN -> DONE on the cycle cycle_cnt increments to MAX_CYCLES.
  - DONE holds until clear.
  - clear=1 in any state -> IDLE next edge. Counters, FIFO and overflow are zeroed. clear has priority over every other input.
- RUN sampling occurs on edges with enable=1. enable=0 in RUN pauses sampling: no counter change and no push; the state stays RUN.
  - cycle_cnt +1 every sampled cycle.
  - stall=1: stall_cnt +1, no push (the repeated instruction is not traced).
  - stall=0: push {pc, instr}. If the FIFO is full and there is no simultaneous pop, the new entry is dropped (oldest entries kept) and overflow is set.
  - jump_flag != 0: jump_cnt +1, independent of stall.
  - stall_cnt and jump_cnt saturate at all-ones. cycle_cnt cannot exceed MAX_CYCLES.
- The entering-DONE cycle is sampled normally. Nothing is sampled in IDLE or DONE.
- Read:
  - rd_req=1 with FIFO non-empty pops the head. rd_valid=1 the next cycle with that data, so latency is 1.
  - rd_req on an empty FIFO: ignored, rd_valid=0.
  - rd_valid is a 1-cycle pulse. rd_pc/rd_instr hold their last value otherwise.
  - Reads are allowed in any state except during clear.
- Simultaneous push and pop: both happen and trace_count is unchanged. This includes the full case, where the push is accepted and overflow is not set. On an empty FIFO, a push and pop in the same cycle leaves the pop ignored; the entry is readable from the next cycle.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. trace_count ranges 0..DEPTH.
- done=1 iff state DONE. busy=1 iff state RUN.
- Reset asserted mid-run: immediate return to reset values. No partial trace is retained.

Test Plan:
- Reset then enable with stall=0, jump_flag=0, and pc stepping 0,4,8,… for 25 cycles -> done=1 after the 25th sampled edge, cycle_cnt=25, trace_count=16, overflow=1, and reads return pc 0..60 in order.
- Stall=1 on cycles 3 and 4, jump_flag=3'b010 on cycle 6, MAX_CYCLES=10 -> stall_cnt=2, jump_cnt=1, trace_count=8, and the FIFO holds no duplicate of the stalled PC.
- Full FIFO with rd_req=1 and a push in the same cycle -> trace_count stays 16, overflow stays 0, and the next pop returns the second-oldest entry.
- rd_req on an empty FIFO -> rd_valid stays 0 and trace_count stays 0.
- Drop enable for 5 cycles mid-run -> cycle_cnt frozen for those 5 cycles, and done is delayed by exactly 5 cycles.
- Assert reset low asynchronously mid-RUN -> all outputs return to 0 before the next clock edge. Assert clear in DONE -> IDLE, counters 0, done=0.
